key_entry_ctrl: RTL

Sequences multi-digit numeric entry from the PS/2 keyboard receiver into a validated value for the downstream configuration registers. It consumes raw scan-code bytes, drops break and extended prefixes, and builds a BCD digit buffer with backspace, escape and an inactivity timeout. On Enter it presents the value with a valid/ack handshake. It sits between the PS/2 receiver and the master keyboard FSM's register-load logic.

---
 rtl/key_entry_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/key_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_entry_ctrl
// Brief    : Turns PS/2 set-2 scan codes into a multi-digit BCD value with
//            backspace, escape, inactivity timeout and a valid/ack commit.
// Revision : 1.0 - initial release
// ============================================================================
module key_entry_ctrl #(
    parameter int DIGITS      = 4,
    parameter int TIMEOUT_CYC = 300000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                rx_done_tick,
    input  logic [7:0]          scan_code,
    input  logic                val_ack,
    output logic [4*DIGITS-1:0] val_data,
    output logic                val_valid,
    output logic [4*DIGITS-1:0] entry_buf,
    output logic [3:0]          digit_count,
    output logic                err_pulse,
    output logic                timeout_pulse
);

    localparam int          c_W        = 4 * DIGITS;
    localparam logic [3:0]  c_DIGITS   = 4'(DIGITS);
    localparam logic [31:0] c_TMO_LAST = 32'(TIMEOUT_CYC - 1);

    localparam logic [7:0] c_BRK   = 8'hF0;
    localparam logic [7:0] c_EXT   = 8'hE0;
    localparam logic [7:0] c_BKSP  = 8'h66;
    localparam logic [7:0] c_ESC   = 8'h76;
    localparam logic [7:0] c_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_brk_f, w_brk_nxt;
    logic            r_ext_f, w_ext_nxt;
    logic [c_W-1:0]  r_entry_buf, w_buf_nxt;
    logic [3:0]      r_count, w_count_nxt;
    logic [c_W-1:0]  r_val_data, w_val_data_nxt;
    logic            r_val_valid, w_val_valid_nxt;
    logic            r_err, w_err_nxt;
    logic            r_tmo, w_tmo_nxt;
    logic [31:0]     r_timer, w_timer_nxt;

    logic            w_is_digit;
    logic [3:0]      w_bcd;

    // Map a make code to its BCD digit value, flagging non-digit codes.
    always_comb begin
        w_is_digit = 1'b1;
        w_bcd      = 4'd0;
        case (scan_code)
            8'h45:   w_bcd = 4'd0;
            8'h16:   w_bcd = 4'd1;
            8'h1E:   w_bcd = 4'd2;
            8'h26:   w_bcd = 4'd3;
            8'h25:   w_bcd = 4'd4;
            8'h2E:   w_bcd = 4'd5;
            8'h36:   w_bcd = 4'd6;
            8'h3D:   w_bcd = 4'd7;
            8'h3E:   w_bcd = 4'd8;
            8'h46:   w_bcd = 4'd9;
            default: w_is_digit = 1'b0;
        endcase
    end

    // Next-state and next-output logic; enable low overrides every event.
    always_comb begin
        w_state_nxt     = r_state;
        w_brk_nxt       = r_brk_f;
        w_ext_nxt       = r_ext_f;
        w_buf_nxt       = r_entry_buf;
        w_count_nxt     = r_count;
        w_val_data_nxt  = r_val_data;
        w_val_valid_nxt = r_val_valid;
        w_err_nxt       = 1'b0;
        w_tmo_nxt       = 1'b0;
        w_timer_nxt     = r_timer;

        if (!enable) begin
            w_state_nxt     = S_IDLE;
            w_brk_nxt       = 1'b0;
            w_ext_nxt       = 1'b0;
            w_buf_nxt       = '0;
            w_count_nxt     = 4'd0;
            w_val_valid_nxt = 1'b0;
            w_timer_nxt     = 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_COLLECT;
                    w_timer_nxt = 32'd0;
                end

                S_COLLECT: begin
                    if (rx_done_tick) begin
                        // Any key activity restarts the idle timer, even in the timeout cycle.
                        w_timer_nxt = 32'd0;
                        if (scan_code == c_BRK) begin
                            w_brk_nxt = 1'b1;
                        end else if (scan_code == c_EXT) begin
                            w_ext_nxt = 1'b1;
                        end else if (r_brk_f || r_ext_f) begin
                            // Byte following a prefix is swallowed, never decoded.
                            w_brk_nxt = 1'b0;
                            w_ext_nxt = 1'b0;
                        end else if (w_is_digit) begin
                            if (r_count < c_DIGITS) begin
                                w_buf_nxt      = r_entry_buf << 4;
                                w_buf_nxt[3:0] = w_bcd;
                                w_count_nxt    = r_count + 4'd1;
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end else if (scan_code == c_BKSP) begin
                            if (r_count != 4'd0) begin
                                w_buf_nxt   = r_entry_buf >> 4;
                                w_count_nxt = r_count - 4'd1;
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end else if (scan_code == c_ESC) begin
                            w_buf_nxt   = '0;
                            w_count_nxt = 4'd0;
                        end else if (scan_code == c_ENTER) begin
                            if (r_count != 4'd0) begin
                                w_val_data_nxt  = r_entry_buf;
                                w_val_valid_nxt = 1'b1;
                                w_state_nxt     = S_HOLD;
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else if (r_count == 4'd0) begin
                        w_timer_nxt = 32'd0;
                    end else if (r_timer == c_TMO_LAST) begin
                        w_buf_nxt   = '0;
                        w_count_nxt = 4'd0;
                        w_tmo_nxt   = 1'b1;
                        w_timer_nxt = 32'd0;
                    end else begin
                        w_timer_nxt = r_timer + 32'd1;
                    end
                end

                S_HOLD: begin
                    w_timer_nxt = 32'd0;
                    // Only prefix tracking happens here; make codes are dropped silently.
                    if (rx_done_tick) begin
                        if (scan_code == c_BRK) begin
                            w_brk_nxt = 1'b1;
                        end else if (scan_code == c_EXT) begin
                            w_ext_nxt = 1'b1;
                        end else begin
                            w_brk_nxt = 1'b0;
                            w_ext_nxt = 1'b0;
                        end
                    end
                    if (val_ack) begin
                        w_val_valid_nxt = 1'b0;
                        w_buf_nxt       = '0;
                        w_count_nxt     = 4'd0;
                        w_state_nxt     = S_COLLECT;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, flag and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_brk_f     <= 1'b0;
            r_ext_f     <= 1'b0;
            r_entry_buf <= '0;
            r_count     <= 4'd0;
            r_val_data  <= '0;
            r_val_valid <= 1'b0;
            r_err       <= 1'b0;
            r_tmo       <= 1'b0;
            r_timer     <= 32'd0;
        end else begin
            r_brk_f     <= w_brk_nxt;
            r_ext_f     <= w_ext_nxt;
            r_entry_buf <= w_buf_nxt;
            r_count     <= w_count_nxt;
            r_val_data  <= w_val_data_nxt;
            r_val_valid <= w_val_valid_nxt;
            r_err       <= w_err_nxt;
            r_tmo       <= w_tmo_nxt;
            r_timer     <= w_timer_nxt;
        end
    end

    assign val_data      = r_val_data;
    assign val_valid     = r_val_valid;
    assign entry_buf     = r_entry_buf;
    assign digit_count   = r_count;
    assign err_pulse     = r_err;
    assign timeout_pulse = r_tmo;

endmodule
`default_nettype wire
